// File: rtl/serial_adder_pkg.sv
// ============================================================================
// serial_adder_pkg
// Shared types and helpers for the bit-serial adder/subtractor.
// Revision: 1.0
// ============================================================================
`default_nettype none

package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit-counter width: enough to count 0..WIDTH-1, never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_adder_full_adder.sv
// ============================================================================
// full_adder
// One-bit full adder assembled from two half-adder cells and an OR gate.
// Revision: 1.0
// ============================================================================
`default_nettype none

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic w_ha0_s;
  logic w_ha0_c;
  logic w_ha1_c;

  assign w_ha0_s = a ^ b;
  assign w_ha0_c = a & b;

  assign s       = w_ha0_s ^ ci;
  assign w_ha1_c = w_ha0_s & ci;

  assign co      = w_ha0_c | w_ha1_c;

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// serial_adder
// Bit-serial add/subtract, LSB first, one full-adder cell, WIDTH+1 cycles/op.
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             m_clock,
  input  logic             p_reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q,  carry_d;
  logic             c_msb_q,  c_msb_d;

  logic             w_fa_s;
  logic             w_fa_co;
  logic [WIDTH-1:0] w_result_shift;

  full_adder u_full_adder (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (w_fa_s),
    .co (w_fa_co)
  );

  // Sum bits enter at the MSB so after WIDTH shifts bit 0 lands at the LSB.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign w_result_shift = w_fa_s;
    end else begin : g_res_wn
      assign w_result_shift = {w_fa_s, result_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    carry_d  = carry_q;
    c_msb_d  = c_msb_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        result_d = w_result_shift;
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        carry_d  = w_fa_co;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == C_LAST) begin
          c_msb_d = carry_q;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      c_msb_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      c_msb_q  <= c_msb_d;
    end
  end

  // Carry and c_msb are untouched outside RUN, so cout/ovf hold until next start.
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign s    = result_q;
  assign cout = carry_q;
  assign ovf  = c_msb_q ^ carry_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// tb_serial_adder
// Directed checks for serial_adder at WIDTH=8 and WIDTH=1.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_serial_adder;

  logic       m_clock = 1'b0;
  logic       p_reset;
  logic       start,  sub,  cin;
  logic [7:0] a, b;
  logic       busy, done, cout, ovf;
  logic [7:0] s;

  logic       start1, sub1, cin1;
  logic [0:0] a1, b1, s1;
  logic       busy1, done1, cout1, ovf1;

  int total = 0;
  int bad   = 0;

  always #5 m_clock = ~m_clock;

  serial_adder #(.WIDTH(8)) dut (
    .m_clock (m_clock), .p_reset (p_reset), .start (start), .sub (sub),
    .a (a), .b (b), .cin (cin), .busy (busy), .done (done),
    .s (s), .cout (cout), .ovf (ovf)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .m_clock (m_clock), .p_reset (p_reset), .start (start1), .sub (sub1),
    .a (a1), .b (b1), .cin (cin1), .busy (busy1), .done (done1),
    .s (s1), .cout (cout1), .ovf (ovf1)
  );

  typedef struct {
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge m_clock);
    @(negedge m_clock);
  endtask

  // Called at a negedge with the DUT in IDLE or DONE; returns at the
  // negedge of the DONE cycle (cycle 9), so a following call is back-to-back.
  task automatic run_op(input string tag, input logic sb, input logic [7:0] aa,
                        input logic [7:0] bb, input logic ci, input logic [7:0] es,
                        input logic ec, input logic eo, input bit noise);
    int terr;
    terr  = 0;
    start = 1'b1; sub = sb; a = aa; b = bb; cin = ci;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (busy !== 1'b1 || done !== 1'b0) terr++;
      if (noise) begin
        start = k[0];
        sub   = ~sb;
        a     = 8'($urandom);
        b     = 8'($urandom);
        cin   = ~ci;
      end
      tick();
    end
    start = 1'b0;
    chk({tag, "_busy_timing"}, terr, 0);
    chk({tag, "_done"}, {busy, done}, 2'b01);
    chk({tag, "_s"}, s, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"}, ovf, eo);
  endtask

  initial begin
    vecs[0] = '{1'b0, 8'd3,   8'd5,   1'b0, 8'd8,   1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'd255, 8'd1,   1'b0, 8'd0,   1'b1, 1'b0};
    vecs[2] = '{1'b0, 8'd127, 8'd1,   1'b0, 8'd128, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 8'd5,   8'd3,   1'b0, 8'd2,   1'b1, 1'b0};
    vecs[4] = '{1'b1, 8'd3,   8'd5,   1'b0, 8'd254, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 8'd100, 8'd27,  1'b1, 8'd128, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 8'd128, 8'd1,   1'b1, 8'd127, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 8'd200, 8'd100, 1'b0, 8'd44,  1'b1, 1'b0};

    p_reset = 1'b1;
    start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    start1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    @(negedge m_clock);
    tick();
    chk("reset_outputs", {busy, done, s, cout, ovf}, 12'h0);
    chk("reset_outputs_w1", {busy1, done1, s1, cout1, ovf1}, 5'h0);
    p_reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].sub, vecs[i].a, vecs[i].b,
             vecs[i].cin, vecs[i].s, vecs[i].cout, vecs[i].ovf, 1'b0);
      tick();
      chk($sformatf("vec%0d_idle_hold", i), {busy, done, s},
          {2'b00, vecs[i].s});
    end

    // Back-to-back: start issued while in DONE of the previous op.
    run_op("b2b_first", 1'b0, 8'd7, 8'd9, 1'b0, 8'd16, 1'b0, 1'b0, 1'b0);
    run_op("b2b_second", 1'b0, 8'd10, 8'd20, 1'b0, 8'd30, 1'b0, 1'b0, 1'b1);
    tick();

    // Reset during cycle 4 of RUN aborts with no done.
    start = 1'b1; sub = 1'b0; a = 8'd50; b = 8'd60; cin = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    p_reset = 1'b1;
    tick();
    p_reset = 1'b0;
    chk("abort_outputs", {busy, done, s, cout, ovf}, 12'h0);
    begin
      int seen_done;
      seen_done = 0;
      for (int k = 0; k < 12; k++) begin
        if (done !== 1'b0 || busy !== 1'b0) seen_done++;
        tick();
      end
      chk("abort_no_done", seen_done, 0);
    end
    run_op("after_abort", 1'b0, 8'd1, 8'd1, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0);
    tick();

    // Reset and start together: reset wins.
    p_reset = 1'b1; start = 1'b1; a = 8'd4; b = 8'd4;
    tick();
    p_reset = 1'b0; start = 1'b0;
    chk("reset_beats_start", {busy, done, s}, 10'h0);
    tick();

    // WIDTH=1: carry into MSB and out of MSB both 1, so no overflow.
    start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; sub1 = 1'b0;
    tick();
    start1 = 1'b0;
    chk("w1_cycle1", {busy1, done1}, 2'b10);
    tick();
    chk("w1_cycle2_done", {busy1, done1}, 2'b01);
    chk("w1_result", {s1, cout1, ovf1}, 3'b110);
    tick();
    chk("w1_idle", {busy1, done1, s1}, 3'b001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
